// File: rtl/invol_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// invol_arbiter_pkg
// Shared definitions for the involuntary-send arbiter: unit IDs, index width,
// arbiter state encoding and small index helpers.
// -----------------------------------------------------------------------------
package invol_arbiter_pkg;

    localparam int NUNITS    = 5;
    localparam int UNIT_BITS = $clog2(NUNITS);

    // Requesting units, by bit position in invol_req / unit_done / invol_grant.
    localparam logic [UNIT_BITS-1:0] UNIT_PWM     = UNIT_BITS'(0);
    localparam logic [UNIT_BITS-1:0] UNIT_SYSTEM  = UNIT_BITS'(1);
    localparam logic [UNIT_BITS-1:0] UNIT_STEPPER = UNIT_BITS'(2);
    localparam logic [UNIT_BITS-1:0] UNIT_TMCUART = UNIT_BITS'(3);
    localparam logic [UNIT_BITS-1:0] UNIT_GPIO    = UNIT_BITS'(4);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_e;

    // OR-encode a one-hot vector into a binary index. No priority is needed
    // because at most one bit is ever set.
    function automatic logic [UNIT_BITS-1:0] onehot_to_idx(input logic [NUNITS-1:0] oh);
        logic [UNIT_BITS-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUNITS; i++) begin
            if (oh[i]) idx = idx | UNIT_BITS'(i);
        end
        return idx;
    endfunction

    // Round-robin successor; NUNITS is not a power of two, so wrap explicitly.
    function automatic logic [UNIT_BITS-1:0] next_ptr(input logic [UNIT_BITS-1:0] k);
        return (k == UNIT_BITS'(NUNITS - 1)) ? '0 : k + 1'b1;
    endfunction

endpackage

// File: rtl/invol_arbiter_if.sv
// -----------------------------------------------------------------------------
// invol_arbiter_if
// Bundle between the requesting units / dispatcher and the arbiter.
//   invol_req   : per-unit level request, held until served
//   path_idle   : dispatcher idle and no inbound message pending
//   unit_done   : per-unit cmd_done pulse
//   invol_grant : one-hot single-cycle grant pulse
//   sel_unit    : index of the unit owning the response path
//   busy        : response path owned by the arbiter
//   timeout     : single-cycle pulse when the watchdog aborts a grant
//   timeout_cnt : saturating abort count
// master = units/dispatcher side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface invol_arbiter_if;
    import invol_arbiter_pkg::*;

    logic [NUNITS-1:0]    invol_req;
    logic                 path_idle;
    logic [NUNITS-1:0]    unit_done;
    logic [NUNITS-1:0]    invol_grant;
    logic [UNIT_BITS-1:0] sel_unit;
    logic                 busy;
    logic                 timeout;
    logic [7:0]           timeout_cnt;

    modport master (
        output invol_req, path_idle, unit_done,
        input  invol_grant, sel_unit, busy, timeout, timeout_cnt
    );

    modport slave (
        input  invol_req, path_idle, unit_done,
        output invol_grant, sel_unit, busy, timeout, timeout_cnt
    );

endinterface

// File: rtl/invol_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority select: the first set bit of req searching
// rr, rr+1, ... NUNITS-1, then wrapping to 0.
//   req   : request vector
//   rr    : round-robin start index
//   pick  : one-hot selected unit (0 when nothing requests)
//   valid : some unit requests
// -----------------------------------------------------------------------------
module rr_pick
    import invol_arbiter_pkg::*;
(
    input  logic [NUNITS-1:0]    req,
    input  logic [UNIT_BITS-1:0] rr,
    output logic [NUNITS-1:0]    pick,
    output logic                 valid
);

    // One extra bit so rr + offset cannot overflow before the wrap.
    logic [UNIT_BITS:0] idx_sum;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; a missing default would infer a latch.
        pick    = '0;
        valid   = 1'b0;
        idx_sum = '0;
        for (int i = 0; i < NUNITS; i++) begin
            idx_sum = {1'b0, rr} + (UNIT_BITS + 1)'(i);
            if (idx_sum >= (UNIT_BITS + 1)'(NUNITS)) idx_sum = idx_sum - (UNIT_BITS + 1)'(NUNITS);
            if (!valid && req[idx_sum[UNIT_BITS-1:0]]) begin
                pick[idx_sum[UNIT_BITS-1:0]] = 1'b1;
                valid                        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/invol_arbiter.sv
// -----------------------------------------------------------------------------
// invol_arbiter
// Round-robin owner of the shared response path (send ring + length FIFO).
// Grants one requesting unit only while the dispatcher reports path_idle,
// tracks it until its done pulse, and aborts it with a watchdog so a hung
// unit cannot lock the path.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : invol_arbiter_if.slave (requests, path_idle, done in; grant,
//           sel_unit, busy, timeout, timeout_cnt out)
// Parameters: TIMEOUT = max cycles a grant may stay outstanding,
//             TO_BITS = watchdog counter width.
// -----------------------------------------------------------------------------
module invol_arbiter
    import invol_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 48000,
    parameter int TO_BITS = $clog2(TIMEOUT)
) (
    input  logic           clk,
    input  logic           rst_n,
    invol_arbiter_if.slave bus
);

    arb_state_e           state;
    logic [UNIT_BITS-1:0] rr;
    logic [TO_BITS-1:0]   wdog;
    logic [NUNITS-1:0]    grant_q;
    logic [UNIT_BITS-1:0] sel_q;
    logic                 busy_q;
    logic                 timeout_q;
    logic [7:0]           tcnt_q;

    logic [NUNITS-1:0]    pick;
    logic                 pick_valid;
    logic [UNIT_BITS-1:0] pick_idx;

    rr_pick u_rr_pick (
        .req   (bus.invol_req),
        .rr    (rr),
        .pick  (pick),
        .valid (pick_valid)
    );

    assign pick_idx = onehot_to_idx(pick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr        <= '0;
            wdog      <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register below updates
            // from pre-edge values regardless of statement order.
            grant_q   <= '0;
            timeout_q <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (bus.path_idle && pick_valid) begin
                        grant_q <= pick;
                        sel_q   <= pick_idx;
                        busy_q  <= 1'b1;
                        wdog    <= '0;
                        rr      <= next_ptr(pick_idx);
                        state   <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    // grant_q is still high only during the grant cycle;
                    // a done sampled then is too early and is ignored.
                    if (bus.unit_done[sel_q] && grant_q == '0) begin
                        state <= ARB_HOLD;
                    end else if (wdog == TO_BITS'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
                        state <= ARB_HOLD;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ARB_HOLD: begin
                    // One extra busy cycle lets the dispatcher refresh path_idle.
                    busy_q <= 1'b0;
                    state  <= ARB_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.invol_grant = grant_q;
    assign bus.sel_unit    = sel_q;
    assign bus.busy        = busy_q;
    assign bus.timeout     = timeout_q;
    assign bus.timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_invol_arbiter.sv
// -----------------------------------------------------------------------------
// tb_invol_arbiter
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a behavioural owner/age model.
// -----------------------------------------------------------------------------
module tb_invol_arbiter;
    import invol_arbiter_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    invol_arbiter_if bus();

    invol_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: owner = -1 when free, age = edges since the grant edge.
    int   m_owner, m_age, m_rr, m_tcnt;
    bit   m_ending;
    logic [NUNITS-1:0]    e_grant;
    logic [UNIT_BITS-1:0] e_sel;
    logic                 e_busy, e_timeout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1; m_age = 0; m_rr = 0; m_tcnt = 0; m_ending = 0;
        e_grant = '0; e_sel = '0; e_busy = 1'b0; e_timeout = 1'b0;
    endfunction

    function automatic void model_edge(input logic [NUNITS-1:0] req, input logic idle,
                                       input logic [NUNITS-1:0] done);
        e_grant   = '0;
        e_timeout = 1'b0;
        if (m_ending) begin
            m_ending = 0;
            m_owner  = -1;
            e_busy   = 1'b0;
        end else if (m_owner >= 0) begin
            m_age++;
            if (m_age >= 2 && done[m_owner]) begin
                m_ending = 1;
            end else if (m_age == TO) begin
                e_timeout = 1'b1;
                if (m_tcnt < 255) m_tcnt++;
                m_ending = 1;
            end
        end else if (idle && req != '0) begin
            for (int i = 0; i < NUNITS; i++) begin
                int k = (m_rr + i) % NUNITS;
                if (m_owner < 0 && req[k]) m_owner = k;
            end
            m_age   = 0;
            e_grant = NUNITS'(1 << m_owner);
            e_sel   = UNIT_BITS'(m_owner);
            e_busy  = 1'b1;
            m_rr    = (m_owner + 1) % NUNITS;
        end
    endfunction

    // One clock: drive inputs (at negedge), advance model at posedge, compare
    // every output at the following negedge.
    task automatic step(input logic [NUNITS-1:0] req, input logic idle, input logic [NUNITS-1:0] done);
        bus.invol_req = req;
        bus.path_idle = idle;
        bus.unit_done = done;
        @(posedge clk);
        model_edge(req, idle, done);
        @(negedge clk);
        cyc++;
        check("grant",       32'(bus.invol_grant), 32'(e_grant));
        check("sel_unit",    32'(bus.sel_unit),    32'(e_sel));
        check("busy",        32'(bus.busy),        32'(e_busy));
        check("timeout",     32'(bus.timeout),     32'(e_timeout));
        check("timeout_cnt", 32'(bus.timeout_cnt), 32'(m_tcnt));
    endtask

    // Asynchronous reset pulse asserted between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_async_busy",  32'(bus.busy),        32'd0);
        check("rst_async_grant", 32'(bus.invol_grant), 32'd0);
        check("rst_tcnt",        32'(bus.timeout_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [NUNITS-1:0] r_req, r_done;
    int order[6];
    int gcyc[6];
    int n, grants;
    bit seen;

    initial begin
        bus.invol_req = '0;
        bus.path_idle = 1'b0;
        bus.unit_done = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_grant",   32'(bus.invol_grant), 32'd0);
        check("reset_sel",     32'(bus.sel_unit),    32'd0);
        check("reset_busy",    32'(bus.busy),        32'd0);
        check("reset_timeout", 32'(bus.timeout),     32'd0);
        rst_n = 1'b1;

        // Single requester, done 4 cycles after the grant.
        step(5'b00100, 1'b1, 5'b0);
        check("single_grant", 32'(bus.invol_grant), 32'b00100);
        check("single_sel",   32'(bus.sel_unit),    32'd2);
        check("single_busy",  32'(bus.busy),        32'd1);
        repeat (3) step(5'b0, 1'b1, 5'b0);
        step(5'b0, 1'b1, 5'b00100);
        check("single_hold_busy", 32'(bus.busy), 32'd1);
        step(5'b0, 1'b1, 5'b0);
        check("single_release", 32'(bus.busy), 32'd0);

        // All requesting, done 2 cycles after each grant.
        do_reset();
        for (int g = 0; g < 6; g++) begin
            seen = 0;
            for (int w = 0; w < 10 && !seen; w++) begin
                step(5'b11111, 1'b1, 5'b0);
                if (bus.invol_grant != '0) seen = 1;
            end
            check("rr_grant_seen", 32'(seen), 32'd1);
            order[g] = int'(bus.sel_unit);
            gcyc[g]  = cyc;
            step(5'b11111, 1'b1, 5'b0);
            step(5'b11111, 1'b1, NUNITS'(1 << order[g]));
        end
        for (int g = 0; g < 6; g++) check("rr_order", 32'(order[g]), 32'(g % NUNITS));
        for (int g = 1; g < 6; g++) check("rr_spacing_ge3", 32'(gcyc[g] - gcyc[g-1] >= 3), 32'd1);
        step(5'b0, 1'b0, 5'b0);

        // Blocking: path not idle for 100 cycles holds off the request.
        grants = 0;
        for (int i = 0; i < 100; i++) begin
            step(5'b00001, 1'b0, 5'b0);
            if (bus.invol_grant != '0) grants++;
        end
        check("block_no_grant", 32'(grants), 32'd0);
        step(5'b00001, 1'b1, 5'b0);
        check("block_grant", 32'(bus.invol_grant), 32'b00001);
        step(5'b0, 1'b0, 5'b0);
        step(5'b0, 1'b0, 5'b00001);
        step(5'b0, 1'b0, 5'b0);

        // Stray done from another unit is ignored.
        step(5'b01000, 1'b1, 5'b0);
        check("stray_grant", 32'(bus.invol_grant), 32'b01000);
        step(5'b0, 1'b0, 5'b0);
        step(5'b0, 1'b0, 5'b00010);
        step(5'b0, 1'b0, 5'b0);
        check("stray_still_busy", 32'(bus.busy), 32'd1);
        step(5'b0, 1'b0, 5'b01000);
        step(5'b0, 1'b0, 5'b0);
        check("stray_release", 32'(bus.busy), 32'd0);

        // Timeout: unit 4 never answers.
        step(5'b10000, 1'b1, 5'b0);
        check("to_grant", 32'(bus.invol_grant), 32'b10000);
        n = 0;
        seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            step(5'b0, 1'b1, 5'b0);
            if (bus.timeout) begin seen = 1; n = i; end
        end
        check("to_latency", 32'(n), 32'd16);
        check("to_cnt", 32'(bus.timeout_cnt), 32'd1);
        step(5'b0, 1'b0, 5'b0);
        check("to_busy_drop", 32'(bus.busy), 32'd0);
        step(5'b11111, 1'b1, 5'b0);
        check("to_next_from_0", 32'(bus.invol_grant), 32'b00001);
        step(5'b0, 1'b0, 5'b0);
        step(5'b0, 1'b0, 5'b00001);
        step(5'b0, 1'b0, 5'b0);

        // Reset during the grant pulse.
        step(5'b00100, 1'b1, 5'b0);
        check("mid_grant", 32'(bus.invol_grant), 32'b00100);
        do_reset();
        step(5'b11111, 1'b1, 5'b0);
        check("post_reset_grant", 32'(bus.invol_grant), 32'b00001);

        // Randomized traffic against the model.
        r_req = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int u = 0; u < NUNITS; u++)
                if (!r_req[u] && $urandom_range(0, 7) == 0) r_req[u] = 1'b1;
            r_done = '0;
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) r_done[m_owner] = 1'b1;
            if ($urandom_range(0, 9) == 0) r_done[$urandom_range(0, NUNITS - 1)] = 1'b1;
            step(r_req, $urandom_range(0, 3) != 0, r_done);
            r_req = r_req & ~e_grant;
        end
        step(5'b0, 1'b0, 5'b0);
        step(5'b0, 1'b0, 5'b0);

        // Drive the abort counter into saturation.
        for (int t = 0; t < 260; t++) begin
            seen = 0;
            for (int w = 0; w < 5 && !seen; w++) begin
                step(5'b00010, 1'b1, 5'b0);
                if (bus.invol_grant != '0) seen = 1;
            end
            for (int i = 0; i < 20 && !bus.timeout; i++) step(5'b0, 1'b0, 5'b0);
        end
        step(5'b0, 1'b0, 5'b0);
        check("tcnt_saturated", 32'(bus.timeout_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/invol_arbiter.md
Name: invol_arbiter

Overview:
- Round-robin scheduler for the shared response path (send ring + send length FIFO) among units raising involuntary-send requests (pwm, system, stepper, tmcuart, gpio).
- Sits beside the command dispatcher. It grants at most one unit at a time, and only while the dispatcher reports the response path idle.
- Tracks the granted unit until its done, with a watchdog timeout so a hung unit cannot lock the response path.

Parameters:
- NUNITS, 5, number of requesting units.
- UNIT_BITS, $clog2(NUNITS), width of the unit index.
- TIMEOUT, 48000, maximum cycles a grant may stay outstanding (1 ms at 48 MHz).
- TO_BITS, $clog2(TIMEOUT), width of the watchdog counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- invol_req  in  NUNITS  per-unit level request; held until the unit is served.
- path_idle  in  1  dispatcher idle and no inbound message pending.
- unit_done  in  NUNITS  per-unit cmd_done pulse.
- invol_grant  out  NUNITS  one-hot, single-cycle grant pulse.
- sel_unit  out  UNIT_BITS  index of the unit owning the response path.
- busy  out  1  response path owned by the arbiter.
- timeout  out  1  single-cycle pulse when the watchdog aborts a grant.
- timeout_cnt  out  8  saturating count of aborts.

Behaviour:
- Reset values (async on rst_n low):
  - invol_grant=0, sel_unit=0, busy=0, timeout=0, timeout_cnt=0.
  - Round-robin pointer rr=0; state ARB_IDLE; watchdog counter 0.
- State ARB_IDLE:
  - When path_idle && |invol_req, pick the first requesting unit searching rr, rr+1, … NUNITS-1, wrapping to 0.
  - Register the grant at that edge: invol_grant[k]=1 for exactly one cycle, sel_unit=k, busy=1, wdog=0, rr=(k+1) mod NUNITS.
  - Transition to ARB_WAIT.
  - Latency: request and path_idle sampled high at edge N gives the grant visible in cycle N+1.
- When path_idle is low or there is no request, nothing happens; a pending request is held off indefinitely with no grant and no counting.
- State ARB_WAIT:
  - busy=1; the watchdog increments each cycle.
  - unit_done[sel_unit]=1 → ARB_HOLD.
  - unit_done from any other unit is ignored.
  - unit_done[sel_unit] in the same cycle as the grant pulse is ignored; a unit must respond at least one cycle later.
  - wdog==TIMEOUT-1 without done → timeout pulse, timeout_cnt+=1 (saturating at 255), → ARB_HOLD.
  - If done and timeout coincide, done wins: no timeout pulse, no count.
- State ARB_HOLD:
  - One cycle with busy=1 so the dispatcher re-evaluates path_idle, then → ARB_IDLE with busy=0.
  - Back-to-back grants are therefore at least 3 cycles apart.
- Deassertion of invol_req while in ARB_WAIT does not cancel the grant; only done or timeout ends it.
- path_idle is sampled only in ARB_IDLE.
- Fairness: with all units requesting continuously, grants go 0,1,2,3,4,0,… No unit waits more than NUNITS-1 grants.
- rst_n low mid-operation returns to ARB_IDLE immediately and drops busy asynchronously. A grant pulse in flight is cut short.
- Width rules:
  - Pointer increment wraps explicitly at NUNITS; it is not a power-of-2 wrap.
  - sel_unit is a plain binary index. One-hot to index is a priority-free encode, valid because the grant is one-hot.

Decomposition:
- Shared package holds:
  - unit IDs: UNIT_PWM=0, UNIT_SYSTEM=1, UNIT_STEPPER=2, UNIT_TMCUART=3, UNIT_GPIO=4, NUNITS=5;
  - UNITS_BITS;
  - arbiter state encodings ARB_IDLE, ARB_WAIT, ARB_HOLD.
- One natural sub-module, rr_pick: combinational rotate-priority select taking req and rr, returning a one-hot pick and a valid flag. The FSM, watchdog and counters stay in invol_arbiter.

Test Plan:
- Single requester: req=5'b00100, path_idle=1 → grant=00100 one cycle later, sel_unit=2, busy=1. unit_done[2] 4 cycles later → busy low 2 cycles after done.
- All requesting, done 2 cycles after each grant:
  - required grant order is 0,1,2,3,4,0;
  - spacing between consecutive grants ≥3 cycles.
- Blocking: req=00001 with path_idle=0 for 100 cycles → no grant. Raise path_idle → grant to unit 0 one cycle later.
- Stray done: unit 3 granted, unit_done[1] pulsed → still busy. unit_done[3] → release.
- Timeout with TIMEOUT=16: grant unit 4, never done → timeout pulse in wait cycle 16, timeout_cnt=1, busy drops. Next pending request is served starting from unit 0.
- Reset mid-grant: rst_n low during ARB_WAIT → busy/grant 0 asynchronously, rr=0. After release, req=11111 → first grant to unit 0.
